// File: rtl/cpu_state_reader_pkg.sv
// Shared types and defaults for the CPU state read-out engine.
// The FSM encoding, target select codes and default bus widths live here.
package cpu_state_reader_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 2;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_state_reader_fifo.sv
// Small first-word-fall-through FIFO for {addr, last, data} entries.
// The head entry is visible combinationally; push and pop may coincide at any occupancy.
module cpu_state_reader_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;

    assign do_pop = pop && (count_reg != '0);
    assign head   = mem_reg[rd_ptr_reg];
    assign count  = count_reg;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cpu_state_reader.sv
// Debug read-out engine: freezes the CPU, reads a range of register-file or
// data-memory words through a synchronous read port and streams them out.
module cpu_state_reader
    import cpu_state_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_sel,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [ADDR_WIDTH:0]     cmd_count,
    output logic                    cpu_hold,
    output logic                    rd_en,
    output logic                    rd_sel,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    out_last,
    output logic                    done
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_WIDTH + 1 + DATA_WIDTH;

    state_t                  state_reg;
    logic                    sel_reg;
    logic [ADDR_WIDTH-1:0]   base_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic [ADDR_WIDTH:0]     issued_reg;
    logic                    inflight_reg;
    logic [ADDR_WIDTH-1:0]   land_addr_reg;
    logic                    land_last_reg;
    logic                    cmd_ready_reg;
    logic                    cpu_hold_reg;
    logic                    done_reg;

    logic [CNT_W-1:0]        fifo_count;
    logic [ENTRY_W-1:0]      fifo_head;
    logic [ENTRY_W-1:0]      fifo_in;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [CNT_W:0]          occupancy;
    logic                    issue;
    logic                    last_issue;
    logic                    handshake;
    logic                    drained;
    logic [ADDR_WIDTH-1:0]   issue_addr;

    // Words already buffered plus the one still on its way back from the read port.
    assign fifo_empty = (fifo_count == '0);
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign issue      = (state_reg == ST_READ) && (issued_reg != count_reg)
                        && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign issue_addr = base_reg + issued_reg[ADDR_WIDTH-1:0];
    assign last_issue = ((issued_reg + (ADDR_WIDTH + 1)'(1)) == count_reg);

    assign handshake  = out_valid && out_ready;
    assign drained    = (occupancy == {{CNT_W{1'b0}}, handshake});

    // A landing word bypasses the empty buffer when it is consumed on arrival.
    assign fifo_pop   = !fifo_empty && out_ready;
    assign fifo_push  = inflight_reg && !(fifo_empty && out_ready);
    assign fifo_in    = {land_addr_reg, land_last_reg, rd_data};

    cpu_state_reader_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        out_valid = !fifo_empty || inflight_reg;
        out_addr  = '0;
        out_last  = 1'b0;
        out_data  = '0;
        if (!fifo_empty) begin
            {out_addr, out_last, out_data} = fifo_head;
        end else if (inflight_reg) begin
            {out_addr, out_last, out_data} = fifo_in;
        end
    end

    assign rd_en     = issue;
    assign rd_sel    = sel_reg;
    assign rd_addr   = issue_addr;
    assign cmd_ready = cmd_ready_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign done      = done_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= SEL_REG;
            base_reg      <= '0;
            count_reg     <= '0;
            issued_reg    <= '0;
            inflight_reg  <= 1'b0;
            land_addr_reg <= '0;
            land_last_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            cpu_hold_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                issued_reg    <= issued_reg + (ADDR_WIDTH + 1)'(1);
                land_addr_reg <= issue_addr;
                land_last_reg <= last_issue;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sel_reg       <= cmd_sel;
                        base_reg      <= cmd_base;
                        count_reg     <= cmd_count;
                        issued_reg    <= '0;
                        cmd_ready_reg <= 1'b0;
                        cpu_hold_reg  <= 1'b1;
                        if (cmd_count == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_HALT;
                        end
                    end
                end
                // One quiet cycle so the CPU's in-flight write commits before reads start.
                ST_HALT: begin
                    state_reg <= ST_READ;
                end
                ST_READ: begin
                    if (issue && last_issue) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    done_reg      <= 1'b0;
                    cpu_hold_reg  <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_state_reader.sv
// Scoreboard bench for cpu_state_reader: directed commands push expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_cpu_state_reader;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_sel;
    logic [7:0]  cmd_base;
    logic [8:0]  cmd_count;
    logic        cpu_hold;
    logic        rd_en;
    logic        rd_sel;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_addr;
    logic        out_last;
    logic        done;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  addr;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_rel = 0;

    logic [31:0] rf   [32];
    logic [31:0] dmem [256];

    cpu_state_reader dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_base  (cmd_base),
        .cmd_count (cmd_count),
        .cpu_hold  (cpu_hold),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous read port: data appears the cycle after the strobe.
    always @(posedge clock) begin
        if (rd_en) rd_data <= rd_sel ? dmem[rd_addr] : rf[rd_addr[4:0]];
        else       rd_data <= 32'hA5A5_A5A5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur_rel);
        end
    endtask

    task automatic expect_word(input logic [31:0] data, input logic [7:0] addr, input logic last);
        exp_t e;
        e.data = data;
        e.addr = addr;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Monitor: compares each handshake against the scoreboard and checks hold stability.
    logic        prev_v, prev_r, prev_last, have_prev;
    logic [31:0] prev_d;
    logic [7:0]  prev_a;

    always @(negedge clock) begin
        if (!reset) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_v && !prev_r) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, prev_d);
                check("hold_addr", {24'd0, out_addr}, {24'd0, prev_a});
                check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got addr=%02h data=%08h expected no word", out_addr, out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_addr", {24'd0, out_addr}, {24'd0, e.addr});
                    check("word_last", {31'd0, out_last}, {31'd0, e.last});
                    $display("word cycle=%0d addr=%02h data=%08h last=%0d", cur_rel, out_addr, out_data, out_last);
                end
            end
            have_prev = 1'b1;
            prev_v    = out_valid;
            prev_r    = out_ready;
            prev_d    = out_data;
            prev_a    = out_addr;
            prev_last = out_last;
        end
    end

    // Issues one command and walks it cycle by cycle; cycle 1 is the one after the accept edge.
    task automatic run_cmd(input logic sel, input logic [7:0] base, input logic [8:0] cnt,
                           input int s_from, input int s_to, input int exp_first,
                           input int exp_done, input int exp_early);
        int rel, first, reads, early;
        bit seen_done, finished;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_base  = base;
        cmd_count = cnt;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        rel = 1; first = 0; reads = 0; early = 0;
        seen_done = 1'b0; finished = 1'b0;
        while (!finished) begin
            cur_rel   = rel;
            out_ready = !(rel >= s_from && rel <= s_to);
            if (rd_en) begin
                reads++;
                if (rel <= s_to) early++;
            end
            if (out_valid && first == 0) first = rel;
            if (seen_done) begin
                check("hold_after_done", {31'd0, cpu_hold}, 32'd0);
                check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
                check("done_one_cycle", {31'd0, done}, 32'd0);
                finished = 1'b1;
            end else begin
                check("cpu_hold", {31'd0, cpu_hold}, 32'd1);
                check("cmd_ready", {31'd0, cmd_ready}, 32'd0);
                if (done) begin
                    check("done_cycle", rel, exp_done);
                    seen_done = 1'b1;
                end else if (rel >= 60) begin
                    checks++;
                    errors++;
                    $display("FAIL done_timeout: got no done by cycle %0d expected done at %0d", rel, exp_done);
                    finished = 1'b1;
                end
            end
            if (!finished) begin
                @(posedge clock);
                #1;
                rel++;
            end
        end
        check("read_count", reads, {23'd0, cnt});
        check("first_valid", first, exp_first);
        if (exp_early >= 0) check("reads_before_stall_end", early, exp_early);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("cmd sel=%0d base=%02h count=%0d reads=%0d done_cycle=%0d", sel, base, cnt, reads, rel - 1);
        out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++)  rf[i]   = 32'hB000_0000 | i;
        for (int i = 0; i < 256; i++) dmem[i] = 32'hC000_0000 | i;
        rf[9]      = 32'hDEAD_BEEF;
        dmem[16]   = 32'h0000_00FF;
        dmem[17]   = 32'd1;
        dmem[18]   = 32'd2;
        dmem[19]   = 32'd3;
        dmem[8'hFE] = 32'h1111_00FE;
        dmem[8'hFF] = 32'h2222_00FF;
        dmem[8'h00] = 32'h3333_0000;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = 1'b0;
        cmd_base  = 8'd0;
        cmd_count = 9'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single register-file word
        expect_word(32'hDEAD_BEEF, 8'd9, 1'b1);
        run_cmd(1'b0, 8'd9, 9'd1, 1000, -1, 3, 4, -1);

        // Four memory words, consumer always ready
        expect_word(32'h0000_00FF, 8'd16, 1'b0);
        expect_word(32'd1, 8'd17, 1'b0);
        expect_word(32'd2, 8'd18, 1'b0);
        expect_word(32'd3, 8'd19, 1'b1);
        run_cmd(1'b1, 8'd16, 9'd4, 1000, -1, 3, 7, -1);

        // Same range with back-pressure on cycles 3..8
        expect_word(32'h0000_00FF, 8'd16, 1'b0);
        expect_word(32'd1, 8'd17, 1'b0);
        expect_word(32'd2, 8'd18, 1'b0);
        expect_word(32'd3, 8'd19, 1'b1);
        run_cmd(1'b1, 8'd16, 9'd4, 3, 8, 3, 13, 2);

        // Address wrap past the top of memory
        expect_word(32'h1111_00FE, 8'hFE, 1'b0);
        expect_word(32'h2222_00FF, 8'hFF, 1'b0);
        expect_word(32'h3333_0000, 8'h00, 1'b1);
        run_cmd(1'b1, 8'hFE, 9'd3, 1000, -1, 3, 6, -1);

        // Empty command
        run_cmd(1'b1, 8'd40, 9'd0, 1000, -1, 0, 1, -1);

        // Reset in the middle of an 8-word read
        for (int i = 0; i < 8; i++) expect_word(32'hC000_0020 + i, 8'h20 + i[7:0], i == 7);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_sel   = 1'b1;
        cmd_base  = 8'h20;
        cmd_count = 9'd8;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        cur_rel = 4;
        check("mid_read_rd_en", {31'd0, rd_en}, 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        exp_q.delete();
        check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mrst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("mrst_rd_en", {31'd0, rd_en}, 32'd0);
        check("mrst_rd_sel", {31'd0, rd_sel}, 32'd0);
        check("mrst_rd_addr", {24'd0, rd_addr}, 32'd0);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_data", out_data, 32'd0);
        check("mrst_out_addr", {24'd0, out_addr}, 32'd0);
        check("mrst_out_last", {31'd0, out_last}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("post_rst_done", {31'd0, done}, 32'd0);
        end

        // Fresh command after the mid-read reset
        expect_word(32'hDEAD_BEEF, 8'd9, 1'b1);
        run_cmd(1'b0, 8'd9, 9'd1, 1000, -1, 3, 4, -1);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_state_reader.md
# cpu_state_reader

Debug read-out engine for the single-cycle CPU: accepts a dump command, freezes the CPU, reads a range of register-file or data-memory words through a dedicated synchronous read port, and streams them out over a valid/ready interface. It sits beside `cpu`, is the hardware counterpart of the bench's end-of-run state checks, and feeds a host link or on-chip checker.

## Interface
- `DATA_WIDTH`, 32, word width of register file and data memory
- `ADDR_WIDTH`, 8, word-address width; register file uses low 5 bits
- `FIFO_DEPTH`, 2, output buffer entries (fixed power of two, ≥2)

- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_sel`  in  1  0 = register file, 1 = data memory
- `cmd_base`  in  ADDR_WIDTH  first word address
- `cmd_count`  in  ADDR_WIDTH+1  number of words (0 legal)
- `cpu_hold`  out  1  CPU enable is gated by ~cpu_hold
- `rd_en`  out  1  read strobe
- `rd_sel`  out  1  target of read
- `rd_addr`  out  ADDR_WIDTH  read address
- `rd_data`  in  DATA_WIDTH  valid exactly one cycle after `rd_en`
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer accepts
- `out_data`  out  DATA_WIDTH  word read
- `out_addr`  out  ADDR_WIDTH  address of that word
- `out_last`  out  1  final word of command
- `done`  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, HALT, READ, DRAIN, DONE.
- IDLE: `cmd_ready`=1; on `cmd_valid` latch sel/base/count -> HALT (count 0 -> DONE directly, `cpu_hold` still asserted one cycle).
- HALT: `cpu_hold`=1, no reads; one cycle lets the CPU's in-flight write commit -> READ.
- READ: issue `rd_en` when `fifo_count + inflight < FIFO_DEPTH` and words remain; `rd_addr` = base + issued index, wraps mod 2^ADDR_WIDTH; returning `rd_data` pushed with its address and last flag. After last issue -> DRAIN.
- DRAIN: wait until in-flight read landed and FIFO empty -> DONE.
- DONE: `done`=1 one cycle, `cpu_hold` drops -> IDLE.
- `cpu_hold`=1 in HALT, READ, DRAIN, DONE.
- FIFO never overflows by construction; push and pop in the same cycle legal at any occupancy.
- `cmd_*` ignored outside IDLE.

## Timing
- Reset: state IDLE, `cmd_ready`=1, `cpu_hold`=0, `rd_en`=0, `rd_sel`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `done`=0, FIFO empty, in-flight discarded.
- Command accepted at edge 0: HALT cycle 1, first `rd_en` cycle 2, first `out_valid` cycle 3.
- `out_ready` held high: one word per cycle, N words end on cycle N+2; `done` one cycle after last handshake.
- `out_valid`/`out_data`/`out_addr`/`out_last` stable while `out_valid` && !`out_ready`.
- `out_ready` low: at most FIFO_DEPTH words buffered, issue stalls, resumes the cycle after a pop.
- Reset mid-command: everything returns to reset values next edge; no `done`, no partial word emitted afterwards.

## Structure
- Shared package: state encoding enum, `SEL_REG`/`SEL_MEM` constants, default widths.
- One sub-module: `cpu_state_reader_fifo` (synchronous FIFO carrying {addr, last, data}, count, simultaneous push/pop).
- Top: FSM, issue counter, in-flight flag, `cpu_hold`.

## Test plan
- Regfile[9]=32'hDEADBEEF, cmd sel=0 base=9 count=1, `out_ready`=1 -> cycle 3 `out_valid` with data DEADBEEF, addr 9, last=1; `done` cycle 4.
- RAM[16]=32'hFF, RAM[17..19]=1,2,3, sel=1 base=16 count=4 -> FF,1,2,3 on consecutive cycles, last only on addr 19, `cpu_hold` high cycles 1–7.
- Same as above with `out_ready` low cycles 3–8 -> no loss, no duplicates, at most 2 reads before stall, order preserved.
- sel=1 base=8'hFE count=3 -> addresses FE, FF, 00.
- count=0 -> no `rd_en`, no `out_valid`, `done` pulse one cycle after accept.
- Reset low during READ of count=8 -> next cycle all outputs at reset values, `cmd_ready`=1, new command runs cleanly.
